gf_acc_32: RTL and testbench
============================

Name: gf_acc_32

Overview:
- Downstream accumulator for the GF(2^32) multiplier output stream.
- Consumes one product per cycle from the multiplier's o_o/o_done pair.
- XOR-accumulates (GF(2^32) addition) exactly N_TERMS products into an inner-product result.
- Holds the result for the next stage and reports protocol violations.

Parameters:
- WIDTH, 32, field element width in bits; must match the multiplier output.
- N_TERMS, 16, number of products per inner product; legal range 1..65535.
- CNT_W, $clog2(N_TERMS+1), width of the term counter and of o_cnt.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; clears the accumulator and begins a new inner product.
- i_prod  in  WIDTH  product from the multiplier o_o.
- i_prod_valid  in  1  product qualifier from the multiplier o_done.
- o_acc  out  WIDTH  final inner-product result; stable while in HOLD.
- o_done  out  1  one-cycle pulse when o_acc becomes valid.
- o_busy  out  1  high while in ACC.
- o_cnt  out  CNT_W  number of products absorbed into the current vector.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, i_rst_n=0): state=IDLE; acc, o_acc, o_cnt, o_done, o_busy and o_err all 0.
- States: IDLE, ACC, HOLD. o_busy=1 only in ACC. o_busy, o_acc and o_cnt are registered.
- IDLE/HOLD + i_start:
  - Go to ACC; acc<=0; o_cnt<=0.
  - If i_prod_valid is high in the same cycle, that product is term 0: acc<=i_prod, o_cnt<=1.
- ACC + i_prod_valid (no i_start): acc<=acc^i_prod; o_cnt<=o_cnt+1.
- Completion (last term):
  - Condition: o_cnt==N_TERMS-1 and i_prod_valid, or N_TERMS==1 with start+valid together.
  - Next cycle: o_acc=final XOR, o_done=1 for exactly one cycle, state=HOLD, o_cnt=N_TERMS.
  - Latency: o_done is asserted the cycle after the last valid product.
- HOLD: o_acc and o_cnt held until the next i_start. o_acc is not cleared by i_start; it updates only at the next completion.
- ACC + i_start: abort.
  - acc and o_cnt restart as in the IDLE/HOLD + i_start case, including same-cycle valid.
  - o_err<=1.
  - o_acc keeps its previous value; no o_done.
- i_prod_valid in IDLE or HOLD without i_start: product dropped; o_err<=1; acc and o_acc unchanged.
- o_err clears only on reset.
- Back-to-back vectors: i_start may coincide with the o_done cycle (state HOLD); the new vector starts with no bubble. The multiplier can therefore stream continuously at one product per cycle.
- Gaps: i_prod_valid may deassert any number of cycles inside ACC; there is no timeout.
- Arithmetic: bitwise XOR only, no carries. The counter never exceeds N_TERMS.
- Reset mid-operation: immediate return to IDLE with all outputs 0; partial accumulation discarded.

Test Plan:
- Basic sum (N_TERMS=4):
  - Stimulus: start, then valid products 0x11111111, 0x22222222, 0x44444444, 0x88888888 on consecutive cycles.
  - Required: o_done one cycle after the 4th product, o_acc=0xFFFFFFFF, o_cnt=4, o_err=0.
- Gapped stream with start+valid overlap (N_TERMS=4):
  - Stimulus: start with valid 0x12345678 in the same cycle, then 0x12345678, 0xDEADBEEF, 0x00000001 separated by 2 idle cycles each.
  - Required: o_acc=0xDEADBEEE, single o_done pulse.
- Back-to-back vectors (N_TERMS=2):
  - Stimulus: vector A = 0xAAAA0000, 0x0000AAAA; i_start on A's o_done cycle; vector B = 0x5555FFFF, 0x55550000.
  - Required: o_acc=0xAAAAAAAA then 0x0000FFFF, two o_done pulses 2 cycles apart, o_err=0.
- Abort:
  - Stimulus: after 2 of 4 terms, pulse i_start, then 4 products of 0x00000003.
  - Required: o_err=1 and stays 1; o_acc=0x00000000; exactly one o_done.
- Stray product:
  - Stimulus: valid 0xFFFFFFFF while in HOLD with o_acc=0x0000FFFF.
  - Required: o_acc stays 0x0000FFFF; o_err=1; no o_done.
- Reset mid-vector:
  - Stimulus: drop i_rst_n asynchronously (between clock edges) after 3 terms.
  - Required: o_acc, o_cnt, o_busy and o_err are 0 immediately; the next full vector completes normally.

Source files
------------

// File: rtl/gf_acc_32.sv
// gf_acc_32: XOR-accumulates N_TERMS GF(2^32) products into an inner-product result
module gf_acc_32 #(
  parameter int WIDTH   = 32,
  parameter int N_TERMS = 16,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_prod,
  input  logic             i_prod_valid,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_TERMS);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, o_acc_n;
  logic [CNT_W-1:0] cnt_n;
  logic done_n, err_n;
  always_comb begin
    state_n = state;
    acc_n   = acc;
    o_acc_n = o_acc;
    cnt_n   = o_cnt;
    done_n  = 1'b0;
    err_n   = o_err;
    if (i_start) begin
      acc_n   = i_prod_valid ? i_prod : '0;
      cnt_n   = CNT_W'(i_prod_valid);
      err_n   = o_err | (state == ACC);
      state_n = ACC;
      if (i_prod_valid && N_TERMS == 1) begin
        o_acc_n = i_prod;
        done_n  = 1'b1;
        state_n = HOLD;
        cnt_n   = FULL;
      end
    end else if (i_prod_valid) begin
      if (state == ACC) begin
        acc_n = acc ^ i_prod;
        cnt_n = o_cnt + 1'b1;
        if (o_cnt == LAST) begin
          o_acc_n = acc ^ i_prod;
          done_n  = 1'b1;
          state_n = HOLD;
        end
      end else begin
        err_n = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      o_acc  <= '0;
      o_cnt  <= '0;
      o_done <= 1'b0;
      o_busy <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      o_acc  <= o_acc_n;
      o_cnt  <= cnt_n;
      o_done <= done_n;
      o_busy <= state_n == ACC;
      o_err  <= err_n;
    end
  end
endmodule

// File: tb/tb_gf_acc_32.sv
// tb_gf_acc_32: randomized and directed checks of gf_acc_32 for N_TERMS = 4, 2 and 1
module tb_gf_acc_32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic [31:0] prod = '0;
  logic [31:0] acc_o [3];
  logic done_o [3];
  logic busy_o [3];
  logic err_o [3];
  logic [2:0] cnt4;
  logic [1:0] cnt2;
  logic [0:0] cnt1;
  int n_checks = 0;
  int n_fail = 0;
  int nt [3] = '{4, 2, 1};
  bit act [3];
  logic [31:0] sum [3];
  logic [31:0] oacc [3];
  int cnt_m [3];
  bit done_m [3];
  bit err_m [3];
  int cyc = 0;
  int done4_cnt = 0;
  int done2_cyc [$];
  always #5 clk = ~clk;
  gf_acc_32 #(.N_TERMS(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_prod(prod),
    .i_prod_valid(valid), .o_acc(acc_o[0]), .o_done(done_o[0]), .o_busy(busy_o[0]), .o_cnt(cnt4), .o_err(err_o[0]));
  gf_acc_32 #(.N_TERMS(2)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_prod(prod),
    .i_prod_valid(valid), .o_acc(acc_o[1]), .o_done(done_o[1]), .o_busy(busy_o[1]), .o_cnt(cnt2), .o_err(err_o[1]));
  gf_acc_32 #(.N_TERMS(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_prod(prod),
    .i_prod_valid(valid), .o_acc(acc_o[2]), .o_done(done_o[2]), .o_busy(busy_o[2]), .o_cnt(cnt1), .o_err(err_o[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic compare_all();
    int c;
    for (int k = 0; k < 3; k++) begin
      c = k == 0 ? int'(cnt4) : k == 1 ? int'(cnt2) : int'(cnt1);
      check($sformatf("acc_n%0d", nt[k]), acc_o[k], oacc[k]);
      check($sformatf("done_n%0d", nt[k]), 32'(done_o[k]), 32'(done_m[k]));
      check($sformatf("busy_n%0d", nt[k]), 32'(busy_o[k]), 32'(act[k]));
      check($sformatf("cnt_n%0d", nt[k]), 32'(c), 32'(cnt_m[k]));
      check($sformatf("err_n%0d", nt[k]), 32'(err_o[k]), 32'(err_m[k]));
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      act[k] = 0; sum[k] = '0; oacc[k] = '0; cnt_m[k] = 0; done_m[k] = 0; err_m[k] = 0;
    end
  endtask
  task automatic model_step(input bit s, input bit v, input logic [31:0] p);
    for (int k = 0; k < 3; k++) begin
      done_m[k] = 0;
      if (s) begin
        if (act[k]) err_m[k] = 1;
        sum[k] = v ? p : '0;
        cnt_m[k] = v ? 1 : 0;
        if (v && nt[k] == 1) begin
          oacc[k] = p; done_m[k] = 1; act[k] = 0;
        end else act[k] = 1;
      end else if (v) begin
        if (act[k]) begin
          sum[k] ^= p;
          cnt_m[k]++;
          if (cnt_m[k] == nt[k]) begin
            oacc[k] = sum[k]; done_m[k] = 1; act[k] = 0;
          end
        end else err_m[k] = 1;
      end
    end
  endtask
  task automatic step(input bit s, input bit v, input logic [31:0] p);
    start = s; valid = v; prod = p;
    @(posedge clk);
    #1;
    cyc++;
    model_step(s, v, p);
    compare_all();
    if (done_o[0]) done4_cnt++;
    if (done_o[1]) done2_cyc.push_back(cyc);
    start = 0; valid = 0; prod = '0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    // basic sum
    step(1, 0, 0);
    step(0, 1, 32'h11111111);
    step(0, 1, 32'h22222222);
    step(0, 1, 32'h44444444);
    step(0, 1, 32'h88888888);
    check("basic_acc", acc_o[0], 32'hFFFFFFFF);
    check("basic_done", 32'(done_o[0]), 1);
    check("basic_cnt", 32'(cnt4), 4);
    check("basic_err", 32'(err_o[0]), 0);
    // gapped stream with start+valid overlap
    done4_cnt = 0;
    step(1, 1, 32'h12345678);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 32'h12345678);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 32'hDEADBEEF);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 32'h00000001);
    check("gap_acc", acc_o[0], 32'hDEADBEEE);
    step(0, 0, 0);
    check("gap_done_pulses", 32'(done4_cnt), 1);
    // back-to-back on N_TERMS=2
    do_reset();
    done2_cyc.delete();
    step(1, 0, 0);
    step(0, 1, 32'hAAAA0000);
    step(0, 1, 32'h0000AAAA);
    check("b2b_acc_a", acc_o[1], 32'hAAAAAAAA);
    step(1, 1, 32'h5555FFFF);
    step(0, 1, 32'h55550000);
    check("b2b_acc_b", acc_o[1], 32'h0000FFFF);
    check("b2b_pulses", 32'(done2_cyc.size()), 2);
    if (done2_cyc.size() == 2) check("b2b_spacing", 32'(done2_cyc[1] - done2_cyc[0]), 2);
    check("b2b_err", 32'(err_o[1]), 0);
    // stray product in HOLD
    step(0, 1, 32'hFFFFFFFF);
    check("stray_acc", acc_o[1], 32'h0000FFFF);
    check("stray_err", 32'(err_o[1]), 1);
    check("stray_done", 32'(done_o[1]), 0);
    // abort on N_TERMS=4
    do_reset();
    done4_cnt = 0;
    step(1, 0, 0);
    step(0, 1, $urandom);
    step(0, 1, $urandom);
    step(1, 0, 0);
    repeat (4) step(0, 1, 32'h00000003);
    check("abort_acc", acc_o[0], 32'h00000000);
    check("abort_err", 32'(err_o[0]), 1);
    repeat (3) step(0, 0, 0);
    check("abort_err_sticky", 32'(err_o[0]), 1);
    check("abort_done_pulses", 32'(done4_cnt), 1);
    // asynchronous reset mid-vector
    step(1, 0, 0);
    repeat (3) step(0, 1, $urandom);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_acc", acc_o[0], 0);
    check("rst_cnt", 32'(cnt4), 0);
    check("rst_busy", 32'(busy_o[0]), 0);
    check("rst_err", 32'(err_o[0]), 0);
    compare_all();
    @(negedge clk);
    rst_n = 1;
    done4_cnt = 0;
    step(1, 0, 0);
    repeat (4) step(0, 1, $urandom);
    check("post_rst_done", 32'(done4_cnt), 1);
    check("post_rst_cnt", 32'(cnt4), 4);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) do_reset();
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
